mul_share_sched: RTL and testbench

//  Arbitrates two requesters for one shared WxW multiply. Computes each product as four (W/2)x(W/2) partial products on an external shared half-width multiplier (mul_a/mul_b -> mul_p).

---
 rtl/mul_share_sched.sv | 153 +++++++++++++++
 tb/tb_mul_share_sched.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_sched.sv
// Shared multiply scheduler: two requesters take turns on one W x W multiply.
// Each product is built from four (W/2)x(W/2) partial products on an external
// half-width multiplier and accumulated into a 2W-bit result.
module mul_share_sched #(
    parameter int unsigned W          = 8,
    parameter bit          PRIO_FIXED = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    input  logic [W-1:0]   req0_a,
    input  logic [W-1:0]   req0_b,
    output logic           req0_ready,
    input  logic           req1_valid,
    input  logic [W-1:0]   req1_a,
    input  logic [W-1:0]   req1_b,
    output logic           req1_ready,
    output logic [W/2-1:0] mul_a,
    output logic [W/2-1:0] mul_b,
    input  logic [W-1:0]   mul_p,
    output logic           rsp_valid,
    output logic           rsp_id,
    output logic [2*W-1:0] rsp_prod,
    input  logic           rsp_ready,
    output logic           busy
);

    localparam int unsigned H = W / 2;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PP0  = 3'd1;
    localparam logic [2:0] ST_PP1  = 3'd2;
    localparam logic [2:0] ST_PP2  = 3'd3;
    localparam logic [2:0] ST_PP3  = 3'd4;
    localparam logic [2:0] ST_RSP  = 3'd5;

    logic [2:0]     state;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic           id_q;
    logic           last_grant;
    logic [2*W-1:0] acc;
    logic           grant;
    logic           accept;
    logic [2*W-1:0] mul_ext;
    logic [2*W-1:0] mul_sh_h;
    logic [2*W-1:0] mul_sh_w;

    // Arbitration: a lone requester wins; on contention use fixed or round-robin order
    always_comb begin
        grant = 1'b0;
        if (req0_valid && !req1_valid) begin
            grant = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            grant = 1'b1;
        end else if (req0_valid && req1_valid) begin
            grant = PRIO_FIXED ? 1'b0 : ~last_grant;
        end
    end

    assign req0_ready = (state == ST_IDLE) && !grant && req0_valid;
    assign req1_ready = (state == ST_IDLE) && grant && req1_valid;
    assign accept     = req0_ready || req1_ready;
    assign busy       = (state != ST_IDLE);

    // Steer the latched operand halves to the shared multiplier; idle otherwise
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            ST_PP0: begin
                mul_a = a_q[H-1:0];
                mul_b = b_q[H-1:0];
            end
            ST_PP1: begin
                mul_a = a_q[W-1:H];
                mul_b = b_q[H-1:0];
            end
            ST_PP2: begin
                mul_a = a_q[H-1:0];
                mul_b = b_q[W-1:H];
            end
            ST_PP3: begin
                mul_a = a_q[W-1:H];
                mul_b = b_q[W-1:H];
            end
            default: begin
                mul_a = '0;
                mul_b = '0;
            end
        endcase
    end

    // Partial product widened to 2W before shifting so no bits are lost
    assign mul_ext  = {{W{1'b0}}, mul_p};
    assign mul_sh_h = mul_ext << H;
    assign mul_sh_w = mul_ext << W;

    // Sequencer, operand capture and result accumulation
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= 1'b0;
            last_grant <= 1'b1;
            acc        <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_prod   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        a_q        <= req1_ready ? req1_a : req0_a;
                        b_q        <= req1_ready ? req1_b : req0_b;
                        id_q       <= req1_ready;
                        last_grant <= req1_ready;
                        state      <= ST_PP0;
                    end
                end
                ST_PP0: begin
                    acc   <= mul_ext;
                    state <= ST_PP1;
                end
                ST_PP1: begin
                    acc   <= acc + mul_sh_h;
                    state <= ST_PP2;
                end
                ST_PP2: begin
                    acc   <= acc + mul_sh_h;
                    state <= ST_PP3;
                end
                ST_PP3: begin
                    rsp_prod  <= acc + mul_sh_w;
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
                    state     <= ST_RSP;
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_share_sched.sv
// Directed bench for mul_share_sched: one round-robin instance and one
// fixed-priority instance, each paired with a behavioural half-width multiplier.
module tb_mul_share_sched;

    localparam int unsigned W = 8;
    localparam int unsigned H = W / 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Round-robin instance
    logic           r0v = 1'b0, r1v = 1'b0, r0r, r1r;
    logic [W-1:0]   r0a = '0, r0b = '0, r1a = '0, r1b = '0;
    logic [H-1:0]   ma, mb;
    logic [W-1:0]   mp;
    logic           rv, rid, bsy;
    logic [2*W-1:0] rp;
    logic           rr = 1'b0;

    // Fixed-priority instance
    logic           f0v = 1'b0, f1v = 1'b0, f0r, f1r;
    logic [W-1:0]   f0a = '0, f0b = '0, f1a = '0, f1b = '0;
    logic [H-1:0]   fma, fmb;
    logic [W-1:0]   fmp;
    logic           frv, frid, fbsy;
    logic [2*W-1:0] frp;
    logic           frr = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign mp  = {{H{1'b0}}, ma} * {{H{1'b0}}, mb};
    assign fmp = {{H{1'b0}}, fma} * {{H{1'b0}}, fmb};

    mul_share_sched #(.W(W), .PRIO_FIXED(1'b0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(r0v), .req0_a(r0a), .req0_b(r0b), .req0_ready(r0r),
        .req1_valid(r1v), .req1_a(r1a), .req1_b(r1b), .req1_ready(r1r),
        .mul_a(ma), .mul_b(mb), .mul_p(mp),
        .rsp_valid(rv), .rsp_id(rid), .rsp_prod(rp), .rsp_ready(rr),
        .busy(bsy)
    );

    mul_share_sched #(.W(W), .PRIO_FIXED(1'b1)) dut_fixed (
        .clk(clk), .rst(rst),
        .req0_valid(f0v), .req0_a(f0a), .req0_b(f0b), .req0_ready(f0r),
        .req1_valid(f1v), .req1_a(f1a), .req1_b(f1b), .req1_ready(f1r),
        .mul_a(fma), .mul_b(fmb), .mul_p(fmp),
        .rsp_valid(frv), .rsp_id(frid), .rsp_prod(frp), .rsp_ready(frr),
        .busy(fbsy)
    );

    task automatic idle_inputs();
        r0v = 1'b0; r1v = 1'b0; f0v = 1'b0; f1v = 1'b0;
        rr = 1'b0; frr = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (rv !== 1'b0 || rid !== 1'b0 || rp !== '0 || bsy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: rv=%b rid=%b rp=%h busy=%b, want 0/0/0000/0",
                     rv, rid, rp, bsy);
        end
        n_cmp++;
        if (frv !== 1'b0 || frp !== '0 || fbsy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state_fixed: rv=%b rp=%h busy=%b, want 0/0000/0",
                     frv, frp, fbsy);
        end
        n_cmp++;
        if (ma !== '0 || mb !== '0) begin
            n_err++;
            $display("FAIL mul_idle_zero: mul_a=%h mul_b=%h, want 0/0", ma, mb);
        end
    endtask

    // T1: single req0 request, latency and full-scale product
    task automatic test_single_req0();
        r0v = 1'b1; r0a = 8'hFF; r0b = 8'hFF;
        #1;
        n_cmp++;
        if (r0r !== 1'b1 || r1r !== 1'b0) begin
            n_err++;
            $display("FAIL t1_ready: r0r=%b r1r=%b, want 1/0", r0r, r1r);
        end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            r0v = 1'b0; r0a = 8'h00; r0b = 8'h00;
            if (k <= 4) begin
                n_cmp++;
                if (rv !== 1'b0 || bsy !== 1'b1) begin
                    n_err++;
                    $display("FAIL t1_latency k=%0d: rv=%b busy=%b, want 0/1", k, rv, bsy);
                end
            end
        end
        n_cmp++;
        if (rv !== 1'b1 || rp !== 16'hFE01 || rid !== 1'b0) begin
            n_err++;
            $display("FAIL t1_result: rv=%b rp=%h rid=%b, want 1/fe01/0", rv, rp, rid);
        end
        rr = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (rv !== 1'b0 || bsy !== 1'b0) begin
            n_err++;
            $display("FAIL t1_release: rv=%b busy=%b, want 0/0", rv, bsy);
        end
    endtask

    // T2: req1 alone, busy window exactly five cycles
    task automatic test_single_req1();
        int busy_cnt = 0;
        int seen = 0;
        logic [2*W-1:0] got_p = '0;
        logic got_id = 1'b0;
        rr = 1'b1;
        r1v = 1'b1; r1a = 8'h12; r1b = 8'h34;
        #1;
        n_cmp++;
        if (r1r !== 1'b1 || r0r !== 1'b0) begin
            n_err++;
            $display("FAIL t2_ready: r0r=%b r1r=%b, want 0/1", r0r, r1r);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            r1v = 1'b0;
            if (bsy) busy_cnt++;
            if (rv && seen == 0) begin
                seen = 1; got_p = rp; got_id = rid;
            end
        end
        n_cmp++;
        if (seen != 1 || got_p !== 16'h03A8 || got_id !== 1'b1) begin
            n_err++;
            $display("FAIL t2_result: seen=%0d rp=%h rid=%b, want 1/03a8/1", seen, got_p, got_id);
        end
        n_cmp++;
        if (busy_cnt != 5) begin
            n_err++;
            $display("FAIL t2_busy_cycles: got %0d, want 5", busy_cnt);
        end
    endtask

    // T3: both requesters always valid, round-robin alternation
    task automatic test_round_robin();
        int acc_cnt = 0;
        int rsp_cnt = 0;
        int acc_cyc[4];
        int acc_id[4];
        logic [2*W-1:0] exp_p;
        test_reset();
        rr = 1'b1;
        r0v = 1'b1; r0a = 8'h0F; r0b = 8'hF0;
        r1v = 1'b1; r1a = 8'hA5; r1b = 8'h5A;
        for (int c = 0; c < 24; c++) begin
            #1;
            if (r0r && r1r) begin
                n_cmp++; n_err++;
                $display("FAIL t3_both_ready: cycle %0d", c);
            end
            if (r0r || r1r) begin
                if (acc_cnt < 4) begin
                    acc_cyc[acc_cnt] = c;
                    acc_id[acc_cnt] = r1r ? 1 : 0;
                end
                acc_cnt++;
            end
            if (rv) begin
                exp_p = (rsp_cnt % 2 == 0) ? 16'h0E10 : 16'h3A02;
                n_cmp++;
                if (rid !== rsp_cnt[0] || rp !== exp_p) begin
                    n_err++;
                    $display("FAIL t3_rsp%0d: rid=%b rp=%h, want %0d/%h",
                             rsp_cnt, rid, rp, rsp_cnt % 2, exp_p);
                end
                rsp_cnt++;
            end
            @(negedge clk);
        end
        idle_inputs();
        n_cmp++;
        if (acc_cnt != 4 || rsp_cnt != 4) begin
            n_err++;
            $display("FAIL t3_counts: accepts=%0d rsps=%0d, want 4/4", acc_cnt, rsp_cnt);
        end
        for (int i = 0; i < 4 && i < acc_cnt; i++) begin
            n_cmp++;
            if (acc_cyc[i] != 6 * i || acc_id[i] != i % 2) begin
                n_err++;
                $display("FAIL t3_accept%0d: cycle=%0d id=%0d, want %0d/%0d",
                         i, acc_cyc[i], acc_id[i], 6 * i, i % 2);
            end
        end
    endtask

    // T4: consumer stalls the response; nothing new accepted until it drains
    task automatic test_rsp_stall();
        test_reset();
        rr = 1'b0;
        r0v = 1'b1; r0a = 8'h03; r0b = 8'h07;
        for (int k = 0; k < 5; k++) @(negedge clk);
        r1v = 1'b1; r1a = 8'h09; r1b = 8'h0B;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++;
            if (rv !== 1'b1 || rp !== 16'h0015 || rid !== 1'b0 || r0r !== 1'b0 || r1r !== 1'b0) begin
                n_err++;
                $display("FAIL t4_hold%0d: rv=%b rp=%h rid=%b r0r=%b r1r=%b, want 1/0015/0/0/0",
                         k, rv, rp, rid, r0r, r1r);
            end
            @(negedge clk);
        end
        rr = 1'b1;
        #1;
        n_cmp++;
        if (r0r !== 1'b0 || r1r !== 1'b0) begin
            n_err++;
            $display("FAIL t4_no_accept_in_rsp: r0r=%b r1r=%b, want 0/0", r0r, r1r);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (rv !== 1'b0 || r1r !== 1'b1 || r0r !== 1'b0) begin
            n_err++;
            $display("FAIL t4_resume: rv=%b r0r=%b r1r=%b, want 0/0/1", rv, r0r, r1r);
        end
        @(negedge clk);
        r0v = 1'b0; r1v = 1'b0;
        for (int k = 0; k < 6; k++) @(negedge clk);
    endtask

    // T5: reset in the middle of an operation discards it
    task automatic test_reset_mid_op();
        int seen = 0;
        logic got_id = 1'b0;
        logic [2*W-1:0] got_p = '0;
        test_reset();
        rr = 1'b1;
        r0v = 1'b1; r0a = 8'h11; r0b = 8'h11;
        r1v = 1'b1; r1a = 8'h22; r1b = 8'h02;
        #1;
        n_cmp++;
        if (r0r !== 1'b1) begin
            n_err++;
            $display("FAIL t5_first_grant: r0r=%b, want 1", r0r);
        end
        @(negedge clk);
        r0v = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bsy !== 1'b0 || rv !== 1'b0) begin
            n_err++;
            $display("FAIL t5_aborted: busy=%b rv=%b, want 0/0", bsy, rv);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (r1r !== 1'b1) begin
            n_err++;
            $display("FAIL t5_pending_req1: r1r=%b, want 1", r1r);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            r1v = 1'b0;
            if (rv && seen == 0) begin
                seen = 1; got_id = rid; got_p = rp;
            end
        end
        n_cmp++;
        if (seen != 1 || got_id !== 1'b1 || got_p !== 16'h0044) begin
            n_err++;
            $display("FAIL t5_result: seen=%0d rid=%b rp=%h, want 1/1/0044", seen, got_id, got_p);
        end
    endtask

    // T6: fixed priority keeps req0 winning; zero operand gives zero
    task automatic test_fixed_prio();
        int acc0 = 0;
        int acc1 = 0;
        int rsp_cnt = 0;
        test_reset();
        frr = 1'b1;
        f0v = 1'b1; f0a = 8'h00; f0b = 8'hAB;
        f1v = 1'b1; f1a = 8'h33; f1b = 8'h44;
        for (int c = 0; c < 24; c++) begin
            #1;
            if (f0r) acc0++;
            if (f1r) acc1++;
            if (frv) begin
                rsp_cnt++;
                n_cmp++;
                if (frid !== 1'b0 || frp !== 16'h0000) begin
                    n_err++;
                    $display("FAIL t6_rsp: rid=%b rp=%h, want 0/0000", frid, frp);
                end
            end
            @(negedge clk);
        end
        idle_inputs();
        n_cmp++;
        if (acc0 != 4 || acc1 != 0 || rsp_cnt != 4) begin
            n_err++;
            $display("FAIL t6_counts: acc0=%0d acc1=%0d rsps=%0d, want 4/0/4", acc0, acc1, rsp_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_req0();
        test_single_req1();
        test_round_robin();
        test_rsp_stall();
        test_reset_mid_op();
        test_fixed_prio();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
